// File: rtl/bkg_scan_scheduler.sv
// Background scan scheduler: picks the background ROM per frame, applies horizontal scroll,
// and turns the scan position into a 2-stage ROM-address / palette-index pipeline.
module bkg_scan_scheduler #(
  parameter int SRC_W_LOG2 = 8,
  parameter int SRC_H      = 240
) (
  input  logic        axi_aclk,
  input  logic        axi_aresetn,
  input  logic [9:0]  drawX,
  input  logic [9:0]  drawY,
  input  logic        vde,
  input  logic        frame_start,
  input  logic        bkg_sel_req,
  input  logic        scroll_en,
  input  logic [3:0]  scroll_step,
  input  logic [2:0]  BKG_data,
  output logic        BKG_s,
  output logic [15:0] BKG_addr,
  output logic [2:0]  pix_data,
  output logic        pix_valid,
  output logic [7:0]  scroll_x
);

  typedef enum logic [1:0] {WAIT_FRAME, RUN, BLANK} state_t;

  localparam logic [8:0]  SRC_H_L  = 9'(SRC_H);
  localparam logic [15:0] COL_MASK = 16'((1 << SRC_W_LOG2) - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_bkg_s;
  logic        w_bkg_s_next;
  logic [7:0]  r_scroll_x;
  logic [7:0]  w_scroll_next;

  logic [15:0] r_addr;
  logic        r_s1_valid;
  logic        r_vde_d1;
  logic [2:0]  r_pix_data;
  logic        r_pix_valid;

  logic [8:0]  w_src_y;
  logic [9:0]  w_col_sum;
  logic        w_row_ok;
  logic [15:0] w_addr;

  // Select and scroll only ever move on frame_start, so a frame is never split across ROMs.
  always_comb begin
    w_state_next  = r_state;
    w_bkg_s_next  = r_bkg_s;
    w_scroll_next = r_scroll_x;
    if (frame_start) begin
      case (r_state)
        WAIT_FRAME: begin
          w_state_next = RUN;
          w_bkg_s_next = bkg_sel_req;
        end
        RUN: begin
          if (bkg_sel_req != r_bkg_s) begin
            w_bkg_s_next = bkg_sel_req;
            w_state_next = BLANK;
          end
        end
        BLANK: begin
          if (bkg_sel_req != r_bkg_s) w_bkg_s_next = bkg_sel_req;
          else                        w_state_next = RUN;
        end
        default: w_state_next = WAIT_FRAME;
      endcase
      if (r_state != WAIT_FRAME && scroll_en)
        w_scroll_next = r_scroll_x + {4'd0, scroll_step};
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      r_state    <= WAIT_FRAME;
      r_bkg_s    <= 1'b0;
      r_scroll_x <= 8'd0;
    end else begin
      r_state    <= w_state_next;
      r_bkg_s    <= w_bkg_s_next;
      r_scroll_x <= w_scroll_next;
    end
  end

  // 2x downscale: the low bit of each screen coordinate is dropped.
  assign w_src_y   = drawY[9:1];
  assign w_col_sum = {1'b0, drawX[9:1]} + {2'b00, r_scroll_x};
  assign w_row_ok  = (w_src_y < SRC_H_L);
  assign w_addr    = (16'(w_src_y) << SRC_W_LOG2) | ({6'd0, w_col_sum} & COL_MASK);

  // Pipeline runs every cycle; the FSM only gates the palette index in stage 2.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      r_addr      <= 16'd0;
      r_s1_valid  <= 1'b0;
      r_vde_d1    <= 1'b0;
      r_pix_data  <= 3'd0;
      r_pix_valid <= 1'b0;
    end else begin
      r_addr      <= w_row_ok ? w_addr : 16'd0;
      r_s1_valid  <= w_row_ok;
      r_vde_d1    <= vde;
      r_pix_data  <= (r_s1_valid && r_state == RUN) ? BKG_data : 3'd0;
      r_pix_valid <= r_vde_d1;
    end
  end

  assign BKG_s     = r_bkg_s;
  assign BKG_addr  = r_addr;
  assign pix_data  = r_pix_data;
  assign pix_valid = r_pix_valid;
  assign scroll_x  = r_scroll_x;

endmodule

// File: tb/tb_bkg_scan_scheduler.sv
// Scoreboard bench for bkg_scan_scheduler: stimulus pushes expected values, a negedge monitor pops and compares.
module tb_bkg_scan_scheduler;

  logic        clk = 1'b0;
  logic        rstn;
  logic [9:0]  drawX, drawY;
  logic        vde, frame_start, bkg_sel_req, scroll_en;
  logic [3:0]  scroll_step;
  logic [2:0]  BKG_data;
  logic        BKG_s;
  logic [15:0] BKG_addr;
  logic [2:0]  pix_data;
  logic        pix_valid;
  logic [7:0]  scroll_x;

  always #5 clk = ~clk;

  bkg_scan_scheduler dut (
    .axi_aclk(clk), .axi_aresetn(rstn), .drawX(drawX), .drawY(drawY), .vde(vde),
    .frame_start(frame_start), .bkg_sel_req(bkg_sel_req), .scroll_en(scroll_en),
    .scroll_step(scroll_step), .BKG_data(BKG_data), .BKG_s(BKG_s), .BKG_addr(BKG_addr),
    .pix_data(pix_data), .pix_valid(pix_valid), .scroll_x(scroll_x)
  );

  // ROM stand-in: always odd, so real ROM data is never confused with blanked zero.
  function automatic logic [2:0] rom(input logic s, input logic [15:0] a);
    return (a[2:0] ^ a[10:8] ^ {s, 2'b00}) | 3'b001;
  endfunction
  assign BKG_data = rom(BKG_s, BKG_addr);

  typedef struct { int kind; logic [15:0] exp; } chk_t;
  logic [15:0] addr_q[$];
  logic [2:0]  pix_q[$];
  chk_t        chk_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state (0 = WAIT_FRAME, 1 = RUN, 2 = BLANK)
  int         m_state;
  logic       m_bkg;
  logic [7:0] m_scroll;
  logic       tb_d1, tb_d2;

  always @(posedge clk) begin
    if (!rstn) begin
      tb_d1 <= 1'b0;
      tb_d2 <= 1'b0;
    end else begin
      tb_d1 <= vde;
      tb_d2 <= tb_d1;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk_t c;
    check("pix_valid", {15'd0, pix_valid}, {15'd0, tb_d2});
    if (tb_d1) begin
      if (addr_q.size() == 0) check("addr_underflow", 16'd1, 16'd0);
      else check("BKG_addr", BKG_addr, addr_q.pop_front());
    end
    if (pix_valid) begin
      if (pix_q.size() == 0) check("pix_underflow", 16'd1, 16'd0);
      else check("pix_data", {13'd0, pix_data}, {13'd0, pix_q.pop_front()});
    end
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      case (c.kind)
        0: check("scroll_x", {8'd0, scroll_x}, c.exp);
        1: check("BKG_s", {15'd0, BKG_s}, c.exp);
        2: check("BKG_addr_direct", BKG_addr, c.exp);
        3: check("pix_data_direct", {13'd0, pix_data}, c.exp);
        4: check("pix_valid_direct", {15'd0, pix_valid}, c.exp);
        default: check("queues_drained", 16'(addr_q.size() + pix_q.size()), c.exp);
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_chk(input int kind, input logic [15:0] exp);
    chk_t c;
    c.kind = kind;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  task automatic idle(input int n);
    vde = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic frame(input logic sel, input logic en, input logic [3:0] step);
    bkg_sel_req = sel;
    scroll_en   = en;
    scroll_step = step;
    frame_start = 1'b1;
    vde         = 1'b0;
    if (m_state == 0) begin
      m_state = 1;
      m_bkg   = sel;
    end else begin
      if (en) m_scroll = m_scroll + {4'd0, step};
      if (m_state == 1) begin
        if (sel != m_bkg) begin m_bkg = sel; m_state = 2; end
      end else begin
        if (sel != m_bkg) m_bkg = sel;
        else              m_state = 1;
      end
    end
    tick();
    frame_start = 1'b0;
    push_chk(0, {8'd0, m_scroll});
    push_chk(1, {15'd0, m_bkg});
    $display("frame sel=%0d en=%0d step=%0d -> state=%0d BKG_s=%0d scroll_x=%0d", sel, en, step, m_state, m_bkg, m_scroll);
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y);
    logic [8:0]  sy;
    logic [7:0]  sx;
    logic [15:0] a;
    logic [2:0]  p;
    sy = y[9:1];
    sx = x[8:1] + m_scroll;
    a  = (sy < 9'd240) ? {sy[7:0], sx} : 16'd0;
    p  = (sy < 9'd240 && m_state == 1) ? rom(m_bkg, a) : 3'd0;
    addr_q.push_back(a);
    pix_q.push_back(p);
    drawX = x;
    drawY = y;
    vde   = 1'b1;
    tick();
    vde   = 1'b0;
    $display("pixel x=%0d y=%0d -> expect addr=0x%04h pix=%0d", x, y, a, p);
  endtask

  initial begin
    rstn = 1'b0; drawX = '0; drawY = '0; vde = 1'b0; frame_start = 1'b0;
    bkg_sel_req = 1'b0; scroll_en = 1'b0; scroll_step = '0;
    m_state = 0; m_bkg = 1'b0; m_scroll = 8'd0;
    idle(3);
    push_chk(0, 16'd0); push_chk(1, 16'd0); push_chk(2, 16'd0); push_chk(3, 16'd0); push_chk(4, 16'd0);
    tick();
    rstn = 1'b1;
    tick();

    // Before any frame_start: address computed, pixel blanked
    pix(10'd100, 10'd50);
    idle(2);

    frame(1'b1, 1'b0, 4'd0);
    pix(10'd10, 10'd4);
    pix(10'd0, 10'd0);
    pix(10'd639, 10'd479);
    idle(2);

    // Scroll up to 220, then watch the wrap through 4
    for (int i = 0; i < 22; i++) frame(1'b1, 1'b1, 4'd10);
    for (int i = 0; i < 4; i++) frame(1'b1, 1'b1, 4'd10);
    pix(10'd510, 10'd20);
    pix(10'd502, 10'd20);
    pix(10'd504, 10'd20);
    pix(10'd0, 10'd2);
    idle(2);

    // Background switch blanks one frame; a second flip in BLANK extends it
    frame(1'b0, 1'b1, 4'd3);
    pix(10'd20, 10'd20);
    frame(1'b0, 1'b0, 4'd0);
    pix(10'd20, 10'd20);
    frame(1'b1, 1'b0, 4'd0);
    frame(1'b0, 1'b0, 4'd0);
    pix(10'd40, 10'd60);
    frame(1'b0, 1'b0, 4'd0);
    pix(10'd40, 10'd60);
    idle(2);

    // Rows past the source height, and mid-frame select toggling
    pix(10'd100, 10'd480);
    pix(10'd100, 10'd478);
    bkg_sel_req = ~m_bkg;
    idle(3);
    push_chk(1, {15'd0, m_bkg});
    pix(10'd200, 10'd100);
    idle(3);

    // Reset collides with frame_start in RUN
    rstn = 1'b0;
    frame_start = 1'b1;
    bkg_sel_req = ~m_bkg;
    tick();
    m_state = 0; m_bkg = 1'b0; m_scroll = 8'd0;
    push_chk(0, 16'd0); push_chk(1, 16'd0); push_chk(2, 16'd0); push_chk(3, 16'd0); push_chk(4, 16'd0);
    rstn = 1'b1;
    frame_start = 1'b0;
    tick();
    pix(10'd100, 10'd50);
    frame(1'b1, 1'b1, 4'd5);
    pix(10'd100, 10'd50);
    idle(4);
    push_chk(5, 16'd0);
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bkg_scan_scheduler.md
BKG_SCAN_SCHEDULER -- requirements
Module: bkg_scan_scheduler

Interface
REQ-001 SHALL have parameter SRC_W_LOG2, default 8, meaning background source width is 2^8 = 256 pixels; horizontal wrap is modulo 256.
REQ-002 SHALL have parameter SRC_H, default 240, meaning source rows 0..239; display is 2x scaled onto 640x480.
REQ-003 SHALL have port axi_aclk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-004 SHALL have port axi_aresetn, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port drawX, input, 10 bits: current pixel column.
REQ-006 SHALL have port drawY, input, 10 bits: current pixel row.
REQ-007 SHALL have port vde, input, 1 bit: video data enable for drawX/drawY.
REQ-008 SHALL have port frame_start, input, 1 bit: one-cycle pulse during vertical blanking.
REQ-009 SHALL have port bkg_sel_req, input, 1 bit: requested background (1 = BKG1, 0 = BKG2).
REQ-010 SHALL have port scroll_en, input, 1 bit: enables per-frame horizontal scroll.
REQ-011 SHALL have port scroll_step, input, 4 bits: source pixels added to the scroll per frame.
REQ-012 SHALL have port BKG_data, input, 3 bits: combinational palette index returned by the ROM collection.
REQ-013 SHALL have port BKG_s, output, 1 bit: ROM select driven to the ROM collection.
REQ-014 SHALL have port BKG_addr, output, 16 bits: ROM address.
REQ-015 SHALL have port pix_data, output, 3 bits: palette index to the colour mapper.
REQ-016 SHALL have port pix_valid, output, 1 bit: pix_data qualifier.
REQ-017 SHALL have port scroll_x, output, 8 bits: current horizontal scroll offset.

Function
REQ-018 SHALL implement the FSM states WAIT_FRAME, RUN and BLANK; the FSM SHALL evaluate transitions only in cycles where frame_start=1.
REQ-019 WAIT_FRAME SHALL move to RUN on frame_start and, in that same cycle, load BKG_s with bkg_sel_req.
REQ-020 RUN SHALL handle frame_start as follows: if bkg_sel_req != BKG_s, load BKG_s with bkg_sel_req and move to BLANK; otherwise stay in RUN.
REQ-021 BLANK SHALL handle frame_start as follows: if bkg_sel_req != BKG_s, load BKG_s and stay in BLANK (one further black frame); otherwise move to RUN.
REQ-022 BKG_s SHALL change only in a frame_start cycle, so the select never toggles mid-frame.
REQ-023 On frame_start in RUN or BLANK with scroll_en=1, scroll_x SHALL become (scroll_x + scroll_step) mod 256; with scroll_en=0 it SHALL hold.
REQ-024 scroll_x SHALL NOT update on the frame_start cycle that leaves WAIT_FRAME.
REQ-025 Stage 1 (registered) SHALL compute src_x = (drawX[9:1] + scroll_x) mod 256 and src_y = drawY[9:1], then set BKG_addr = {src_y[7:0], src_x[7:0]}, with maximum value 239*256+255 = 61439.
REQ-026 If drawY[9:1] >= SRC_H, stage 1 SHALL register BKG_addr = 0 and mark the pixel invalid.
REQ-027 Stage 2 (registered) SHALL set pix_data = BKG_data when the stage-1 valid=1 and the state is RUN; otherwise pix_data SHALL be 0.
REQ-028 pix_valid SHALL equal vde delayed by exactly 2 cycles, independent of the FSM state.
REQ-029 Fixed latency SHALL be 2 cycles from drawX/drawY/vde to pix_data/pix_valid; pipeline SHALL have no stalls or bubbles.
REQ-030 The pipeline SHALL run continuously in every state; the state gates only pix_data.
REQ-031 When frame_start and vde are both high in the same cycle, FSM/scroll updates and pipeline advance SHALL both occur; the new scroll_x SHALL affect stage 1 from the next cycle.
REQ-032 Scroll wrap: sum 250+10 SHALL yield 4; source column wrap from 255 to 0 SHALL occur without glitching addr high byte.

Reset
REQ-033 While axi_aresetn=0 at a clock edge, the block SHALL set state=WAIT_FRAME, BKG_s=0, BKG_addr=0, pix_data=0, pix_valid=0, scroll_x=0 and clear both pipeline stages.
REQ-034 Reset asserted mid-frame SHALL take effect at the next edge and override a simultaneous frame_start; the block SHALL then output pix_data=0 until the first frame_start after release.

Verification
REQ-035 Reset release; drive vde=1, drawX=100, drawY=50 before any frame_start -> BKG_addr=0x1932 one cycle later; pix_data=0 and pix_valid=1 two cycles later (WAIT_FRAME).
REQ-036 frame_start with bkg_sel_req=1, then drive drawX=10, drawY=4 -> BKG_s=1; BKG_addr=0x0205 one cycle later; pix_data = BKG_data two cycles later.
REQ-037 scroll_en=1, scroll_step=10, four frames in RUN starting from scroll_x=220 -> scroll_x = 230, 240, 250, 4; drawX=510 at scroll_x=4 -> src_x=3, low address byte 0x03.
REQ-038 Flip bkg_sel_req in RUN at frame_start -> BKG_s toggles in that cycle; the next frame outputs pix_data=0 with pix_valid tracking vde; the following frame outputs ROM data.
REQ-039 drawY=480 with vde=1 -> BKG_addr=0 and pix_data=0; bkg_sel_req toggled mid-frame -> BKG_s unchanged until the next frame_start.
REQ-040 Assert axi_aresetn=0 together with frame_start during RUN -> state returns to WAIT_FRAME, scroll_x=0 and BKG_s=0; all outputs are 0 the next cycle.
